pipeline_ctrl: RTL

- Central stall/flush controller for the five-stage core.
- Takes stall requests from IF, ID, EX and MEM and the MEM-stage exception/ERET redirect.
- Drives the per-register `stall_i`/`flush_i` inputs of the PC register and of the IF2ID, ID2EX, EX2MEM and MEM2WB pipeline registers.
- Drives the fetch-redirect PC, holding a redirect until any outstanding instruction fetch has drained.

---
 rtl/pipe_ctrl_pkg.sv | 20 ++
 rtl/stall_priority.sv | 33 +++
 rtl/pipeline_ctrl.sv | 110 +++++++++++
 3 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline stall/flush controller: stage indices,
// FSM state encoding and the exception flush pattern.
package pipe_ctrl_pkg;

  localparam int unsigned STAGE_NUM  = 5;
  localparam int unsigned STG_PC     = 0;
  localparam int unsigned STG_IF2ID  = 1;
  localparam int unsigned STG_ID2EX  = 2;
  localparam int unsigned STG_EX2MEM = 3;
  localparam int unsigned STG_MEM2WB = 4;

  typedef enum logic {
    RUN,
    DRAIN
  } state_t;

  // Every pipeline register behind the PC gets a bubble on an exception.
  localparam logic [STAGE_NUM-1:0] FLUSH_ALL = 5'b11110;

endpackage

// File: rtl/stall_priority.sv
// Stall request priority encoder: the latest requesting stage holds itself and
// everything upstream, and a bubble is inserted into the register right after it.
module stall_priority #(
  parameter int unsigned STAGE_NUM = 5
) (
  input  logic                 if_req_i,
  input  logic                 id_req_i,
  input  logic                 ex_req_i,
  input  logic                 mem_req_i,
  output logic [STAGE_NUM-1:0] stall_o,
  output logic [STAGE_NUM-1:0] flush_o
);
  import pipe_ctrl_pkg::*;

  always_comb begin
    stall_o = '0;
    flush_o = '0;
    if (mem_req_i) begin
      stall_o[STG_EX2MEM:STG_PC] = '1;
      flush_o[STG_MEM2WB]        = 1'b1;
    end else if (ex_req_i) begin
      stall_o[STG_ID2EX:STG_PC] = '1;
      flush_o[STG_EX2MEM]       = 1'b1;
    end else if (id_req_i) begin
      stall_o[STG_IF2ID:STG_PC] = '1;
      flush_o[STG_ID2EX]        = 1'b1;
    end else if (if_req_i) begin
      stall_o[STG_PC]    = 1'b1;
      flush_o[STG_IF2ID] = 1'b1;
    end
  end

endmodule

// File: rtl/pipeline_ctrl.sv
// Central stall/flush controller with exception redirect held until fetch drains.
// Optional performance counters are built when PIPE_PERF_CNT_EN is defined.
module pipeline_ctrl #(
  parameter int unsigned STAGE_NUM = 5
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 if_req_i,
  input  logic                 id_req_i,
  input  logic                 ex_req_i,
  input  logic                 mem_req_i,
  input  logic                 if_busy_i,
  input  logic                 exc_i,
  input  logic [31:0]          exc_target_i,
  output logic [STAGE_NUM-1:0] stall_o,
  output logic [STAGE_NUM-1:0] flush_o,
  output logic                 redirect_valid_o,
  output logic [31:0]          redirect_pc_o,
  output logic [31:0]          stall_cycles_o,
  output logic [31:0]          flush_count_o
);
  import pipe_ctrl_pkg::*;

  state_t                 state, state_d;
  logic [31:0]            target_q;
  logic [STAGE_NUM-1:0]   pri_stall, pri_flush;

  stall_priority #(.STAGE_NUM(STAGE_NUM)) u_stall_priority (
    .if_req_i  (if_req_i),
    .id_req_i  (id_req_i),
    .ex_req_i  (ex_req_i),
    .mem_req_i (mem_req_i),
    .stall_o   (pri_stall),
    .flush_o   (pri_flush)
  );

  always_comb begin
    state_d          = state;
    stall_o          = '0;
    flush_o          = '0;
    redirect_valid_o = 1'b0;
    redirect_pc_o    = target_q;
    if (!rst_i) begin
      unique case (state)
        RUN: begin
          if (exc_i) begin
            flush_o = FLUSH_ALL;
            if (if_busy_i) begin
              stall_o[STG_PC] = 1'b1;
              state_d         = DRAIN;
            end else begin
              redirect_valid_o = 1'b1;
              redirect_pc_o    = exc_target_i;
            end
          end else begin
            stall_o = pri_stall;
            flush_o = pri_flush;
          end
        end
        DRAIN: begin
          // Fetch data returning during the drain is squashed at IF2ID.
          flush_o[STG_IF2ID] = 1'b1;
          if (if_busy_i) begin
            stall_o[STG_PC] = 1'b1;
          end else begin
            redirect_valid_o = 1'b1;
            state_d          = RUN;
          end
        end
        default: state_d = RUN;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state    <= RUN;
      target_q <= '0;
    end else begin
      state <= state_d;
      if (state == RUN && exc_i && if_busy_i) target_q <= exc_target_i;
    end
  end

`ifdef PIPE_PERF_CNT_EN
  logic [31:0] stall_cnt_q, flush_cnt_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (stall_o[STG_PC])       stall_cnt_q <= stall_cnt_q + 32'd1;
      if (state == RUN && exc_i) flush_cnt_q <= flush_cnt_q + 32'd1;
    end
  end

  assign stall_cycles_o = stall_cnt_q;
  assign flush_count_o  = flush_cnt_q;
`else
  assign stall_cycles_o = '0;
  assign flush_count_o  = '0;
`endif

  // Younger instructions are squashed before DRAIN, so no second exception can arrive.
  a_no_exc_in_drain : assert property (@(posedge clk_i) disable iff (rst_i)
    !(state == DRAIN && exc_i))
    else $error("exc_i asserted while draining a redirect");

endmodule
